instr_encoder: RTL and testbench

Sequential RISC-V instruction encoder, the inverse of the decoder. It accepts a decoded request over valid/ready: operation (`fu_op`), `rs1`, `rs2`, `rd` and a 12-bit immediate. It emits the 32-bit RV64 instruction word over a second valid/ready port. It sits in the formal/sim bench in front of `decoder`, so scoreboard-level stimulus becomes legal instruction streams and each encoded word can be round-tripped through the decoder.

---
 rtl/ariane_pkg.sv | 80 ++++++++
 rtl/instr_enc_fifo.sv | 60 ++++++
 rtl/instr_encoder.sv | 102 ++++++++++
 tb/tb_instr_encoder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Encoding table shared by the instruction encoder and the decoder assertions:
// maps each fu_op onto opcode/funct fields and an instruction format.
package ariane_pkg;

    localparam logic [6:0]  OPCODE_OP    = 7'b0110011;
    localparam logic [6:0]  OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0]  OPCODE_STORE = 7'b0100011;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

    typedef enum logic [5:0] {
        ADD, SUB, SLL, SLTS, SLTU, XORL, SRL, SRA, ORL, ANDL,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
        LB, LH, LW, LD, LBU, LHU, LWU,
        SB, SH, SW, SD,
        ADDW, SUBW, BEQ, BNE, JAL, FLE, FLT, FEQ, CSR_WRITE
    } fu_op;

    typedef enum logic [1:0] {RTYPE, ITYPE, STYPE, ILLEGAL} enc_kind_t;

    typedef struct packed {
        enc_kind_t  kind;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } enc_fields_t;

    function automatic enc_fields_t get_enc_fields(input fu_op op);
        enc_fields_t f;
        f = '{kind: ILLEGAL, opcode: 7'b0, funct3: 3'b0, funct7: 7'b0};
        case (op)
            ADD, SUB, SLL, SLTS, SLTU, XORL, SRL, SRA, ORL, ANDL: begin
                f.kind   = RTYPE;
                f.opcode = OPCODE_OP;
                f.funct7 = (op == SUB || op == SRA) ? 7'h20 : 7'h00;
            end
            MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU: begin
                f.kind   = RTYPE;
                f.opcode = OPCODE_OP;
                f.funct7 = 7'h01;
            end
            LB, LH, LW, LD, LBU, LHU, LWU: begin
                f.kind   = ITYPE;
                f.opcode = OPCODE_LOAD;
            end
            SB, SH, SW, SD: begin
                f.kind   = STYPE;
                f.opcode = OPCODE_STORE;
            end
            default: ;
        endcase
        // funct3 lines up across the R, M, load and store groups by position
        case (op)
            SLL, MULH, LH, SH:       f.funct3 = 3'd1;
            SLTS, MULHSU, LW, SW:    f.funct3 = 3'd2;
            SLTU, MULHU, LD, SD:     f.funct3 = 3'd3;
            XORL, DIV, LBU:          f.funct3 = 3'd4;
            SRL, SRA, DIVU, LHU:     f.funct3 = 3'd5;
            ORL, REM, LWU:           f.funct3 = 3'd6;
            ANDL, REMU:              f.funct3 = 3'd7;
            default:                 f.funct3 = 3'd0;
        endcase
        return f;
    endfunction

    function automatic logic [31:0] encode_word(input enc_fields_t f,
                                                input logic [4:0] rs1,
                                                input logic [4:0] rs2,
                                                input logic [4:0] rd,
                                                input logic [11:0] imm);
        logic [31:0] word;
        case (f.kind)
            RTYPE:   word = {f.funct7, rs2, rs1, f.funct3, rd, f.opcode};
            ITYPE:   word = {imm, rs1, f.funct3, rd, f.opcode};
            STYPE:   word = {imm[11:5], rs2, rs1, f.funct3, imm[4:0], f.opcode};
            default: word = INSTR_NOP;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/instr_enc_fifo.sv
// Generic DEPTH x WIDTH FIFO with synchronous flush; head is read combinationally.
module instr_enc_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign w_pop   = pop_i && !empty_o && !flush_i;
    assign w_push  = push_i && (!full_o || w_pop) && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked by r_count alone.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i;
    end

    assign data_o = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RISC-V instruction encoder: registered encode stage feeding an output FIFO,
// with push/error statistics and a one-cycle error pulse for unsupported ops.
module instr_encoder
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  fu_op             req_op_i,
    input  logic [4:0]       req_rs1_i,
    input  logic [4:0]       req_rs2_i,
    input  logic [4:0]       req_rd_i,
    input  logic [11:0]      req_imm_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [31:0]      instr_o,
    output logic             err_o,
    output logic [CNT_W-1:0] enc_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    enc_fields_t      w_fields;
    logic             w_legal;
    logic [31:0]      w_word;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_occ;
    logic             w_full;
    logic             w_empty;
    logic [31:0]      w_head;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    logic             r_s1_valid;
    logic [31:0]      r_s1_word;
    logic             r_err;
    logic [CNT_W-1:0] r_enc_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    assign w_fields = get_enc_fields(req_op_i);
    assign w_legal  = (w_fields.kind != ILLEGAL);
    assign w_word   = encode_word(w_fields, req_rs1_i, req_rs2_i, req_rd_i, req_imm_i);

    // Stage 1 counts as occupancy so a registered word always finds a free FIFO slot.
    assign w_occ       = w_count + CW'(r_s1_valid);
    assign req_ready_o = (w_occ < CW'(DEPTH));
    assign w_accept    = req_valid_i && req_ready_o && !flush_i;
    assign w_pop       = instr_ready_i && !w_empty;
    assign w_push      = r_s1_valid && !flush_i && (!w_full || w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_word  <= INSTR_NOP;
            r_err      <= 1'b0;
            r_enc_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (flush_i) begin
                r_s1_valid <= 1'b0;
            end else if (w_accept) begin
                r_s1_valid <= w_legal;
                r_s1_word  <= w_word;
            end else if (w_push) begin
                r_s1_valid <= 1'b0;
            end
            if (w_push) r_enc_cnt <= r_enc_cnt + CNT_W'(1);
            if (w_accept && !w_legal && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    instr_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (w_push),
        .data_i  (r_s1_word),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign instr_valid_o = !w_empty;
    assign instr_o       = w_empty ? INSTR_NOP : w_head;
    assign err_o         = r_err;
    assign enc_cnt_o     = r_enc_cnt;
    assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued on acceptance
// and compared when the output port handshakes.
module tb_instr_encoder;
    import ariane_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    fu_op             req_op_i;
    logic [4:0]       req_rs1_i;
    logic [4:0]       req_rs2_i;
    logic [4:0]       req_rd_i;
    logic [11:0]      req_imm_i;
    logic             instr_valid_o;
    logic             instr_ready_i;
    logic [31:0]      instr_o;
    logic             err_o;
    logic [CNT_W-1:0] enc_cnt_o;
    logic [CNT_W-1:0] err_cnt_o;

    always #5 clk_i = ~clk_i;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_op_i      (req_op_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_rd_i      (req_rd_i),
        .req_imm_i     (req_imm_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .err_o         (err_o),
        .enc_cnt_o     (enc_cnt_o),
        .err_cnt_o     (err_cnt_o)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] sb_q[$];
    int          exp_enc = 0;
    int          exp_err = 0;
    int          err_pulses = 0;
    logic        exp_legal = 1'b0;
    logic [31:0] exp_word = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Independent reference encoder written from the instruction formats.
    function automatic logic [32:0] ref_encode(input fu_op op, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [4:0] rd,
                                               input logic [11:0] imm);
        logic [2:0] f3;
        logic [6:0] f7;
        int         kind;
        f3 = 3'd0; f7 = 7'h00; kind = 3;
        case (op)
            ADD:    begin kind = 0; f3 = 3'd0; end
            SUB:    begin kind = 0; f3 = 3'd0; f7 = 7'h20; end
            SLL:    begin kind = 0; f3 = 3'd1; end
            SLTS:   begin kind = 0; f3 = 3'd2; end
            SLTU:   begin kind = 0; f3 = 3'd3; end
            XORL:   begin kind = 0; f3 = 3'd4; end
            SRL:    begin kind = 0; f3 = 3'd5; end
            SRA:    begin kind = 0; f3 = 3'd5; f7 = 7'h20; end
            ORL:    begin kind = 0; f3 = 3'd6; end
            ANDL:   begin kind = 0; f3 = 3'd7; end
            MUL:    begin kind = 0; f3 = 3'd0; f7 = 7'h01; end
            MULH:   begin kind = 0; f3 = 3'd1; f7 = 7'h01; end
            MULHSU: begin kind = 0; f3 = 3'd2; f7 = 7'h01; end
            MULHU:  begin kind = 0; f3 = 3'd3; f7 = 7'h01; end
            DIV:    begin kind = 0; f3 = 3'd4; f7 = 7'h01; end
            DIVU:   begin kind = 0; f3 = 3'd5; f7 = 7'h01; end
            REM:    begin kind = 0; f3 = 3'd6; f7 = 7'h01; end
            REMU:   begin kind = 0; f3 = 3'd7; f7 = 7'h01; end
            LB:     begin kind = 1; f3 = 3'd0; end
            LH:     begin kind = 1; f3 = 3'd1; end
            LW:     begin kind = 1; f3 = 3'd2; end
            LD:     begin kind = 1; f3 = 3'd3; end
            LBU:    begin kind = 1; f3 = 3'd4; end
            LHU:    begin kind = 1; f3 = 3'd5; end
            LWU:    begin kind = 1; f3 = 3'd6; end
            SB:     begin kind = 2; f3 = 3'd0; end
            SH:     begin kind = 2; f3 = 3'd1; end
            SW:     begin kind = 2; f3 = 3'd2; end
            SD:     begin kind = 2; f3 = 3'd3; end
            default: kind = 3;
        endcase
        case (kind)
            0:       return {1'b1, f7, rs2, rs1, f3, rd, 7'b0110011};
            1:       return {1'b1, imm, rs1, f3, rd, 7'b0000011};
            2:       return {1'b1, imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    // Scoreboard / monitor: pop on output handshake, push on request handshake.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            sb_q.delete();
            exp_enc    = 0;
            exp_err    = 0;
            err_pulses = 0;
        end else begin
            if (err_o) err_pulses++;
            if (instr_valid_o && instr_ready_i) begin
                if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 32'd1);
                else check("word", instr_o, sb_q.pop_front());
            end
            if (flush_i) begin
                sb_q.delete();
            end else if (req_valid_i && req_ready_o) begin
                if (exp_legal) begin
                    sb_q.push_back(exp_word);
                    exp_enc++;
                end else begin
                    exp_err++;
                end
            end
        end
    end

    // Drive a request and hold it until accepted; called just after a rising edge.
    task automatic send_exp(input fu_op op, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [11:0] imm,
                            input logic legal, input logic [31:0] word);
        exp_legal   = legal;
        exp_word    = word;
        req_op_i    = op;
        req_rs1_i   = rs1;
        req_rs2_i   = rs2;
        req_rd_i    = rd;
        req_imm_i   = imm;
        req_valid_i = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                @(posedge clk_i); #1;
                req_valid_i = 1'b0;
                return;
            end
            @(posedge clk_i); #1;
            if (t >= 2) instr_ready_i = 1'b1;
        end
        check("send_timeout", {31'b0, req_ready_o}, 32'd1);
        req_valid_i = 1'b0;
    endtask

    task automatic send(input fu_op op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [11:0] imm);
        logic [32:0] r;
        r = ref_encode(op, rs1, rs2, rd, imm);
        send_exp(op, rs1, rs2, rd, imm, r[32], r[31:0]);
    endtask

    task automatic wait_drain();
        instr_ready_i = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk_i);
            if (sb_q.size() == 0 && !instr_valid_o) begin
                @(posedge clk_i); #1;
                return;
            end
        end
        check("drain_timeout", 32'(sb_q.size()), 32'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        logic [32:0] r;
        logic [31:0] first_bp;
        logic [3:0]  cnt0;
        logic [3:0]  ecnt0;
        int          acc;
        int          p0;

        rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_op_i = ADD;
        req_rs1_i = '0; req_rs2_i = '0; req_rd_i = '0; req_imm_i = '0; instr_ready_i = 1'b1;
        #12;
        check("rst_ready", {31'b0, req_ready_o}, 32'd1);
        check("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_instr", instr_o, 32'h0000_0013);
        check("rst_enc_cnt", {28'b0, enc_cnt_o}, 32'd0);
        check("rst_err_cnt", {28'b0, err_cnt_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Latency: accepted in N, visible in N+2
        send_exp(ADD, 5'd1, 5'd2, 5'd3, 12'd0, 1'b1, 32'h002081B3);
        @(negedge clk_i);
        check("lat_n1_valid", {31'b0, instr_valid_o}, 32'd0);
        @(negedge clk_i);
        check("lat_n2_valid", {31'b0, instr_valid_o}, 32'd1);
        check("lat_n2_word", instr_o, 32'h002081B3);
        check("enc_cnt_1", {28'b0, enc_cnt_o}, 32'd1);
        @(posedge clk_i); #1;

        send_exp(SUB, 5'd6, 5'd7, 5'd5, 12'd0, 1'b1, 32'h407302B3);
        send_exp(MUL, 5'd2, 5'd3, 5'd1, 12'd0, 1'b1, 32'h023100B3);
        send_exp(LD, 5'd2, 5'd0, 5'd10, 12'hFF8, 1'b1, 32'hFF813503);
        send_exp(SD, 5'd2, 5'd11, 5'd31, 12'd16, 1'b1, 32'h00B13823);
        wait_drain();
        check("enc_cnt_5", {28'b0, enc_cnt_o}, 32'(exp_enc % 16));

        // Back-pressure: four ADDs offered, two accepted, head held
        instr_ready_i = 1'b0;
        acc = 0;
        r = ref_encode(ADD, 5'd1, 5'd2, 5'd1, 12'd0);
        first_bp = r[31:0];
        for (int t = 0; t < 8; t++) begin
            if (acc < 4) begin
                r = ref_encode(ADD, 5'd1, 5'd2, 5'(acc + 1), 12'd0);
                exp_legal = 1'b1; exp_word = r[31:0];
                req_op_i = ADD; req_rs1_i = 5'd1; req_rs2_i = 5'd2;
                req_rd_i = 5'(acc + 1); req_imm_i = 12'd0; req_valid_i = 1'b1;
            end
            @(negedge clk_i);
            if (req_valid_i && req_ready_o) acc++;
            if (t >= 2) check("bp_hold", instr_o, first_bp);
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b0;
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_ready_low", {31'b0, req_ready_o}, 32'd0);
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        check("full_ready_low", {31'b0, req_ready_o}, 32'd0);
        @(negedge clk_i);
        check("ready_after_pop", {31'b0, req_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        send(ADD, 5'd1, 5'd2, 5'd3, 12'd0);
        send(ADD, 5'd1, 5'd2, 5'd4, 12'd0);
        wait_drain();

        // Unsupported op followed by ADD
        p0 = err_pulses;
        send(FLE, 5'd1, 5'd2, 5'd3, 12'd0);
        @(negedge clk_i);
        check("err_pulse", {31'b0, err_o}, 32'd1);
        check("err_cnt_1", {28'b0, err_cnt_o}, 32'd1);
        @(posedge clk_i); #1;
        send(ADD, 5'd8, 5'd9, 5'd10, 12'd0);
        wait_drain();
        check("err_pulse_once", 32'(err_pulses - p0), 32'd1);
        check("err_low", {31'b0, err_o}, 32'd0);

        // Flush with a request handshaking in the same cycle
        instr_ready_i = 1'b0;
        send(ADD, 5'd4, 5'd5, 5'd6, 12'd0);
        @(posedge clk_i); #1;
        check("pre_flush_valid", {31'b0, instr_valid_o}, 32'd1);
        cnt0 = enc_cnt_o; ecnt0 = err_cnt_o;
        r = ref_encode(ADD, 5'd4, 5'd5, 5'd7, 12'd0);
        exp_legal = 1'b1; exp_word = r[31:0];
        req_op_i = ADD; req_rd_i = 5'd7; req_valid_i = 1'b1; flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_hs_ready", {31'b0, req_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);
        check("flush_valid", {31'b0, instr_valid_o}, 32'd0);
        check("flush_enc_cnt", {28'b0, enc_cnt_o}, {28'b0, cnt0});
        check("flush_err_cnt", {28'b0, err_cnt_o}, {28'b0, ecnt0});
        @(posedge clk_i); #1;
        wait_drain();

        // Asynchronous reset mid-stream
        instr_ready_i = 1'b0;
        send(SUB, 5'd6, 5'd7, 5'd5, 12'd0);
        @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("arst_valid", {31'b0, instr_valid_o}, 32'd0);
        check("arst_instr", instr_o, 32'h0000_0013);
        check("arst_ready", {31'b0, req_ready_o}, 32'd1);
        check("arst_enc_cnt", {28'b0, enc_cnt_o}, 32'd0);
        check("arst_err_cnt", {28'b0, err_cnt_o}, 32'd0);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        instr_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_valid", {31'b0, instr_valid_o}, 32'd0);

        // Error counter saturation
        for (int k = 0; k < 16; k++) send(FLT, 5'(k), 5'd0, 5'd1, 12'd0);
        @(negedge clk_i);
        check("err_cnt_sat", {28'b0, err_cnt_o}, 32'd15);
        @(posedge clk_i); #1;

        // Random mix with random back-pressure; crosses the enc_cnt wrap
        for (int k = 0; k < 24; k++) begin
            instr_ready_i = ($urandom_range(0, 3) != 0);
            send(fu_op'(6'($urandom_range(0, 37))), 5'($urandom), 5'($urandom),
                 5'($urandom), 12'($urandom));
        end
        wait_drain();
        check("enc_cnt_wrap", {28'b0, enc_cnt_o}, 32'(exp_enc % 16));
        check("err_cnt_model", {28'b0, err_cnt_o}, 32'((exp_err > 15) ? 15 : exp_err));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
